// File: rtl/instr_prefetch.sv
// ============================================================================
// instr_prefetch
//   Prefetch queue between instruction memory and the decode stage.
//   Fetches sequential words ahead of the core (one request outstanding at a
//   time), buffers {instruction, pc} pairs in a DEPTH-entry FIFO and presents
//   the head through a valid/ready handshake. A redirect flushes the FIFO and
//   restarts fetching at redirect_pc; a response already in flight at that
//   moment is dropped when it arrives, so no wrong-path word is ever shown.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   imem_req     out  fetch request (held until imem_ack)
//   imem_addr    out  byte address of the requested word
//   imem_ack     in   response valid, word on imem_data
//   imem_data    in   returned instruction word
//   redirect     in   taken jump/branch: flush and restart
//   redirect_pc  in   restart address, qualified by redirect
//   inst_valid   out  FIFO head valid
//   instruction  out  FIFO head instruction word
//   inst_pc      out  FIFO head PC
//   inst_ready   in   downstream consumes the head this cycle
//
// All outputs come straight from registers or registered FIFO storage; there
// is no combinational path from inst_ready or imem_ack to any output.
// ============================================================================
module instr_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_FULL  = DEPTH[CW-1:0];
    localparam logic [CW:0]   FILL_CAP  = DEPTH[CW:0];

    // Architectural state
    logic [31:0]   fetch_pc_r;
    logic [31:0]   addr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          inflight_r;
    logic          discard_r;
    logic [31:0]   ins_mem_r [DEPTH];
    logic [31:0]   pc_mem_r  [DEPTH];

    // Next-state values
    logic [31:0]   fetch_pc_nx_s;
    logic [31:0]   addr_nx_s;
    logic [AW-1:0] rd_ptr_nx_s;
    logic [AW-1:0] wr_ptr_nx_s;
    logic [CW-1:0] count_nx_s;
    logic          inflight_nx_s;
    logic          discard_nx_s;
    logic          ack_done_s;
    logic          push_s;
    logic          pop_s;
    logic [CW:0]   fill_s;
    logic          credit_s;
    logic          full_s;

    assign ack_done_s = inflight_r & imem_ack;
    assign full_s     = (count_r == CNT_FULL);

    // Next-state computation: redirect outranks push, pop and issue
    always_comb begin
        fetch_pc_nx_s = fetch_pc_r;
        addr_nx_s     = addr_r;
        rd_ptr_nx_s   = rd_ptr_r;
        wr_ptr_nx_s   = wr_ptr_r;
        count_nx_s    = count_r;
        inflight_nx_s = inflight_r;
        discard_nx_s  = discard_r;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        fill_s        = {1'b0, count_r};
        credit_s      = 1'b0;

        if (redirect) begin
            count_nx_s    = CNT_ZERO;
            rd_ptr_nx_s   = PTR_ZERO;
            wr_ptr_nx_s   = PTR_ZERO;
            fetch_pc_nx_s = redirect_pc;
            if (inflight_r && !imem_ack) begin
                // Transaction cannot be cancelled: keep req/addr held and
                // drop its response when it eventually arrives.
                discard_nx_s = 1'b1;
            end else begin
                // Memory port is free at this edge (idle, or acking now with
                // the word being dropped), so restart immediately.
                discard_nx_s  = 1'b0;
                inflight_nx_s = 1'b1;
                addr_nx_s     = redirect_pc;
            end
        end else begin
            push_s = ack_done_s && !discard_r;
            pop_s  = (count_r != CNT_ZERO) && inst_ready;

            if (ack_done_s) begin
                inflight_nx_s = 1'b0;
                discard_nx_s  = 1'b0;
            end else begin
                inflight_nx_s = inflight_r;
            end

            if (push_s) begin
                wr_ptr_nx_s   = wr_ptr_r + PTR_ONE;
                fetch_pc_nx_s = fetch_pc_r + 32'd4;
            end else begin
                wr_ptr_nx_s   = wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nx_s = rd_ptr_r;
            end

            count_nx_s = count_r + {{(CW-1){1'b0}}, push_s}
                                 - {{(CW-1){1'b0}}, pop_s};

            // Credit counts the incoming word but not a same-cycle pop: a
            // freed slot only becomes usable from the next cycle.
            fill_s   = {1'b0, count_r} + {{CW{1'b0}}, push_s};
            credit_s = (fill_s < FILL_CAP);

            if (!inflight_nx_s && credit_s) begin
                inflight_nx_s = 1'b1;
                addr_nx_s     = fetch_pc_nx_s;
            end else begin
                addr_nx_s     = addr_r;
            end
        end
    end

    // Control and pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            addr_r     <= RESET_PC;
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            inflight_r <= 1'b0;
            discard_r  <= 1'b0;
        end else begin
            fetch_pc_r <= fetch_pc_nx_s;
            addr_r     <= addr_nx_s;
            rd_ptr_r   <= rd_ptr_nx_s;
            wr_ptr_r   <= wr_ptr_nx_s;
            count_r    <= count_nx_s;
            inflight_r <= inflight_nx_s;
            discard_r  <= discard_nx_s;
        end
    end

    // FIFO storage: cleared on reset, written on an accepted response
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ins_mem_r[i] <= 32'h0000_0000;
                pc_mem_r[i]  <= 32'h0000_0000;
            end
        end else if (push_s) begin
            ins_mem_r[wr_ptr_r] <= imem_data;
            pc_mem_r[wr_ptr_r]  <= addr_r;
        end
    end

    assign imem_req    = inflight_r;
    assign imem_addr   = addr_r;
    assign inst_valid  = (count_r != CNT_ZERO);
    assign instruction = ins_mem_r[rd_ptr_r];
    assign inst_pc     = pc_mem_r[rd_ptr_r];

    instr_prefetch_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .full  (full_s)
    );

endmodule

// ----------------------------------------------------------------------------
// instr_prefetch_chk
//   Protocol checker: the issue credit must make a push into a full FIFO
//   impossible.
//   clk, reset : as the parent;  push : word accepted this edge;
//   full       : FIFO holds DEPTH entries.
// ----------------------------------------------------------------------------
module instr_prefetch_chk (
    input logic clk,
    input logic reset,
    input logic push,
    input logic full
);

    no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule
